wbs_decoder: RTL and testbench
==============================

Name: wbs_decoder

Overview:
- Slave-side counterpart of the master arbiter: takes the single arbitrated Wishbone request stream and routes each transaction to one of NUM_SLAVES slaves.
- Routing is decoded from an address field.
- Latches the request, holds the selected slave's cyc/stb until that slave responds or a timeout expires, then returns one registered ack or err pulse to the master.
- Unmapped addresses and hung slaves yield err, so the bus never locks.

Parameters:
- NUM_SLAVES, 4, number of downstream slaves (2..16).
- SEL_LO, 16, lowest address bit of the slave-select field.
- SEL_BITS, 2, width of the select field; index = wbm_adr_i[SEL_LO+SEL_BITS-1:SEL_LO].
- TIMEOUT, 1023, cycles to wait for a slave ack/err before forcing err (1..65535).

Ports:
- wb_clk_i  in  1  bus clock, all logic on rising edge
- wb_rst_i  in  1  asynchronous, active-low reset
- wbm_cyc_i  in  1  master cycle
- wbm_stb_i  in  1  master strobe
- wbm_we_i  in  1  write enable
- wbm_sel_i  in  2  byte selects
- wbm_adr_i  in  32  address
- wbm_dat_i  in  16  write data
- wbm_dat_o  out  16  read data, registered
- wbm_ack_o  out  1  one-cycle ack pulse
- wbm_err_o  out  1  one-cycle err pulse
- wbs_cyc_o  out  NUM_SLAVES  one-hot cycle
- wbs_stb_o  out  NUM_SLAVES  equal to wbs_cyc_o
- wbs_we_o  out  1  latched we
- wbs_sel_o  out  2  latched sel
- wbs_adr_o  out  32  latched address, passed unmodified
- wbs_dat_o  out  16  latched write data
- wbs_dat_i  in  16*NUM_SLAVES  packed read data, slave k at [16k+15:16k]
- wbs_ack_i  in  NUM_SLAVES  per-slave ack
- wbs_err_i  in  NUM_SLAVES  per-slave err
- timeout_o  out  1  one-cycle pulse when a timeout err is issued

Behaviour:
- Reset (wb_rst_i low, asynchronous): state IDLE, all outputs 0, timeout counter 0, latched index 0. Release is synchronous to wb_clk_i.
- States: IDLE, ACCESS, RESP.
- IDLE, when cyc_i & stb_i are sampled high:
  - Latch we, sel, adr, dat and index.
  - Index < NUM_SLAVES: go to ACCESS; wbs_cyc_o/wbs_stb_o bit[index] is 1 from the next cycle.
  - Index >= NUM_SLAVES: go to RESP with err flagged; no slave strobe is asserted.
- Request pulse length: a one-cycle cyc/stb pulse is a complete request, because the upstream arbiter issues one-cycle strobes. Requests arriving outside IDLE are ignored, not queued.
- ACCESS:
  - The counter increments each cycle while strobe is held.
  - If wbs_ack_i[index] | wbs_err_i[index] is sampled: drop strobe, capture wbs_dat_i slice [index] into wbm_dat_o, record ack or err, go to RESP.
  - If ack and err are sampled together, err wins.
  - ack/err on non-selected slaves is ignored.
  - If counter == TIMEOUT with no response: drop strobe, record err, pulse timeout_o in the RESP cycle, go to RESP.
- RESP: wbm_ack_o or wbm_err_o is high for exactly this one cycle; clear the counter, return to IDLE. A new request is accepted on the following cycle, not during RESP.
- Latency:
  - Request sampled at cycle 0, slave strobe at cycle 1.
  - Slave ack sampled at cycle n gives wbm_ack_o at cycle n+1. Minimum round trip is 2 cycles after the request when the slave acks combinationally in cycle 1.
  - Decode miss gives wbm_err_o at cycle 1.
- wbm_dat_o holds its last captured value until the next capture; it is not updated on err.
- The counter is 16 bits and saturates; it must not wrap within one access.
- Reset asserted mid-access: strobes drop immediately (asynchronous); no ack/err is issued.

Test Plan:
- Read to slave 2 (adr 0x0002_0010), slave acks 3 cycles after strobe with data 0xBEEF -> wbs_cyc_o=4'b0100 for 3 cycles, wbs_adr_o=0x0002_0010, single wbm_ack_o, wbm_dat_o=0xBEEF.
- Write to slave 0 with sel=2'b10, dat 0x1234, immediate ack -> wbs_we_o=1, wbs_dat_o=0x1234, wbs_sel_o=2'b10, wbm_ack_o exactly 2 cycles after the request.
- NUM_SLAVES=3, request to index 3 -> no wbs_cyc_o bit set, wbm_err_o high 1 cycle after the request, no ack.
- TIMEOUT=8, slave never responds -> strobe held 8 cycles then dropped, wbm_err_o and timeout_o pulse together; next request is accepted normally.
- Slave 1 raises ack and err together while slave 3 raises a spurious ack -> only wbm_err_o pulses, wbm_dat_o unchanged.
- Assert reset 2 cycles into an access -> wbs_cyc_o=0 within the same cycle, no wbm_ack_o/wbm_err_o after release, IDLE accepts the next request.

Source files
------------

// File: rtl/wbs_decoder.sv
// wbs_decoder: routes the single arbitrated Wishbone request stream to one of
// NUM_SLAVES slaves, selected by wbm_adr_i[SEL_LO +: SEL_BITS].
// The request is latched in IDLE. The selected slave's cyc/stb is held until
// that slave answers or TIMEOUT cycles elapse. One ack or err pulse is then
// returned to the master. Unmapped indices and hung slaves both return err,
// so the bus can never lock up.
//
// Ports:
//   wb_clk_i, wb_rst_i         clock, asynchronous active-low reset
//   wbm_*_i                    master request (cyc, stb, we, sel, adr, dat)
//   wbm_dat_o                  read data, captured on a slave ack
//   wbm_ack_o, wbm_err_o       one-cycle response pulses to the master
//   wbs_cyc_o, wbs_stb_o       one-hot slave strobes (identical)
//   wbs_we_o/sel_o/adr_o/dat_o latched request fields
//   wbs_dat_i                  packed slave read data, slave k at [16k +: 16]
//   wbs_ack_i, wbs_err_i       per-slave responses
//   timeout_o                  pulses together with wbm_err_o on a timeout
module wbs_decoder #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned SEL_LO     = 16,
  parameter int unsigned SEL_BITS   = 2,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     wbm_cyc_i,
  input  logic                     wbm_stb_i,
  input  logic                     wbm_we_i,
  input  logic [1:0]               wbm_sel_i,
  input  logic [31:0]              wbm_adr_i,
  input  logic [15:0]              wbm_dat_i,
  output logic [15:0]              wbm_dat_o,
  output logic                     wbm_ack_o,
  output logic                     wbm_err_o,
  output logic [NUM_SLAVES-1:0]    wbs_cyc_o,
  output logic [NUM_SLAVES-1:0]    wbs_stb_o,
  output logic                     wbs_we_o,
  output logic [1:0]               wbs_sel_o,
  output logic [31:0]              wbs_adr_o,
  output logic [15:0]              wbs_dat_o,
  input  logic [16*NUM_SLAVES-1:0] wbs_dat_i,
  input  logic [NUM_SLAVES-1:0]    wbs_ack_i,
  input  logic [NUM_SLAVES-1:0]    wbs_err_i,
  output logic                     timeout_o
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic                  req;
  logic [SEL_BITS-1:0]   req_idx;
  logic                  req_mapped;
  logic [SEL_BITS-1:0]   idx_q;
  logic [NUM_SLAVES-1:0] sel_mask;
  logic [15:0]           slv_dat;
  logic                  slv_ack;
  logic                  slv_err;
  logic                  slv_resp;
  logic [15:0]           cnt_q;
  logic                  cnt_expired;
  logic                  err_q;
  logic                  to_q;

  assign req        = wbm_cyc_i & wbm_stb_i;
  assign req_idx    = wbm_adr_i[SEL_LO +: SEL_BITS];
  assign req_mapped = (32'(req_idx) < NUM_SLAVES);

  // One-hot decode of the latched index plus read-data mux. Responses from
  // slaves other than the selected one are masked off here.
  always_comb begin
    sel_mask = '0;
    slv_dat  = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (32'(idx_q) == k) begin
        sel_mask[k] = 1'b1;
        slv_dat     = wbs_dat_i[16*k +: 16];
      end
    end
  end

  assign slv_ack  = |(wbs_ack_i & sel_mask);
  assign slv_err  = |(wbs_err_i & sel_mask);
  assign slv_resp = slv_ack | slv_err;

  // The counter holds the number of strobe cycles already completed. Comparing
  // against TIMEOUT-1 fires in the cycle where the incremented count reaches
  // TIMEOUT, so the strobe is held for exactly TIMEOUT cycles.
  assign cnt_expired = (cnt_q == 16'(TIMEOUT - 1));

  // State register
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = req_mapped ? ACCESS : RESP;
      ACCESS:  if (slv_resp || cnt_expired) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    wbs_cyc_o = '0;
    wbm_ack_o = 1'b0;
    wbm_err_o = 1'b0;
    timeout_o = 1'b0;
    case (state_q)
      ACCESS: wbs_cyc_o = sel_mask;
      RESP: begin
        wbm_ack_o = ~err_q;
        wbm_err_o = err_q;
        timeout_o = to_q;
      end
      default: ;
    endcase
  end

  assign wbs_stb_o = wbs_cyc_o;

  // Request latch, response capture and timeout counter
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      wbs_we_o  <= 1'b0;
      wbs_sel_o <= '0;
      wbs_adr_o <= '0;
      wbs_dat_o <= '0;
      idx_q     <= '0;
      wbm_dat_o <= '0;
      err_q     <= 1'b0;
      to_q      <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (req) begin
            wbs_we_o  <= wbm_we_i;
            wbs_sel_o <= wbm_sel_i;
            wbs_adr_o <= wbm_adr_i;
            wbs_dat_o <= wbm_dat_i;
            idx_q     <= req_idx;
            err_q     <= ~req_mapped;
            to_q      <= 1'b0;
          end
        end
        ACCESS: begin
          if (cnt_q != '1) begin
            cnt_q <= cnt_q + 16'd1;
          end
          if (slv_resp) begin
            // err wins when both arrive together; read data only on a clean ack
            err_q <= slv_err;
            if (!slv_err) begin
              wbm_dat_o <= slv_dat;
            end
          end else if (cnt_expired) begin
            err_q <= 1'b1;
            to_q  <= 1'b1;
          end
        end
        default: begin
          cnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wbs_decoder.sv
module tb_wbs_decoder;

  localparam int unsigned NS = 3;
  localparam int unsigned TO = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           m_cyc, m_stb, m_we;
  logic [1:0]     m_sel;
  logic [31:0]    m_adr;
  logic [15:0]    m_wdat;
  logic [15:0]    m_rdat;
  logic           m_ack, m_err;
  logic [NS-1:0]  s_cyc, s_stb;
  logic           s_we;
  logic [1:0]     s_sel;
  logic [31:0]    s_adr;
  logic [15:0]    s_wdat;
  logic [16*NS-1:0] s_rdat;
  logic [NS-1:0]  s_ack, s_err;
  logic           tmo;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [15:0] exp_dat  = '0;

  always #5 clk = ~clk;

  wbs_decoder #(
    .NUM_SLAVES(NS),
    .SEL_LO    (16),
    .SEL_BITS  (2),
    .TIMEOUT   (TO)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .wbm_cyc_i(m_cyc),
    .wbm_stb_i(m_stb),
    .wbm_we_i (m_we),
    .wbm_sel_i(m_sel),
    .wbm_adr_i(m_adr),
    .wbm_dat_i(m_wdat),
    .wbm_dat_o(m_rdat),
    .wbm_ack_o(m_ack),
    .wbm_err_o(m_err),
    .wbs_cyc_o(s_cyc),
    .wbs_stb_o(s_stb),
    .wbs_we_o (s_we),
    .wbs_sel_o(s_sel),
    .wbs_adr_o(s_adr),
    .wbs_dat_o(s_wdat),
    .wbs_dat_i(s_rdat),
    .wbs_ack_i(s_ack),
    .wbs_err_i(s_err),
    .timeout_o(tmo)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic master_idle();
    m_cyc  = 1'b0;
    m_stb  = 1'b0;
    m_we   = 1'b0;
    m_sel  = '0;
    m_adr  = '0;
    m_wdat = '0;
  endtask

  // Idle cycles: nothing must be strobed or answered.
  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk); #1;
      master_idle();
      s_ack = '0;
      s_err = '0;
      s_rdat = {$urandom, $urandom};
      @(negedge clk);
      chk("idle_cyc", 32'(s_cyc), 32'd0);
      chk("idle_ack", 32'(m_ack), 32'd0);
      chk("idle_err", 32'(m_err), 32'd0);
      chk("idle_rdat", 32'(m_rdat), 32'(exp_dat));
    end
  endtask

  // One complete transaction. The slave answers 'delay' cycles after its
  // strobe first appears (0 = combinational answer in the first strobe
  // cycle); kind 0=ack, 1=err, 2=ack+err. spur adds random ack/err from
  // non-selected slaves; intrude keeps issuing requests while busy.
  task automatic run_txn(input logic [1:0] idx, input logic we, input logic [1:0] sel,
                         input logic [15:0] wdat, input logic [31:0] adr_raw,
                         input logic [15:0] rdata, input int unsigned delay,
                         input int unsigned kind, input bit spur, input bit intrude);
    logic [31:0]   adr;
    bit            mapped;
    int unsigned   resp_cyc;
    bit            exp_err, exp_to;
    logic [NS-1:0] mask, exp_stb;
    adr    = {adr_raw[31:18], idx, adr_raw[15:0]};
    mapped = (int'(idx) < int'(NS));
    if (!mapped) begin
      resp_cyc = 1; exp_err = 1'b1; exp_to = 1'b0;
    end else if (delay + 1 <= TO) begin
      resp_cyc = delay + 2; exp_err = (kind != 0); exp_to = 1'b0;
    end else begin
      resp_cyc = TO + 1; exp_err = 1'b1; exp_to = 1'b1;
    end
    mask = '0;
    if (mapped) mask[idx] = 1'b1;

    for (int unsigned t = 0; t <= resp_cyc; t++) begin
      @(posedge clk); #1;
      if (t == 0) begin
        m_cyc = 1'b1; m_stb = 1'b1; m_we = we; m_sel = sel; m_adr = adr; m_wdat = wdat;
      end else if (intrude) begin
        m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'($urandom); m_sel = 2'($urandom);
        m_adr = $urandom; m_wdat = 16'($urandom);
      end else begin
        master_idle();
      end
      s_rdat = {$urandom, $urandom};
      s_ack  = '0;
      s_err  = '0;
      if (spur) begin
        for (int unsigned k = 0; k < NS; k++) begin
          if (!(mapped && k == int'(idx))) begin
            s_ack[k] = 1'($urandom);
            s_err[k] = 1'($urandom);
          end
        end
      end
      if (mapped && t == delay + 1 && t <= TO) begin
        s_ack[idx] = (kind != 1);
        s_err[idx] = (kind != 0);
        s_rdat[16*idx +: 16] = rdata;
      end
      @(negedge clk);
      exp_stb = (mapped && t >= 1 && t < resp_cyc) ? mask : '0;
      chk("wbs_cyc", 32'(s_cyc), 32'(exp_stb));
      chk("wbs_stb", 32'(s_stb), 32'(exp_stb));
      chk("wbm_ack", 32'(m_ack), 32'(t == resp_cyc && !exp_err));
      chk("wbm_err", 32'(m_err), 32'(t == resp_cyc && exp_err));
      chk("timeout", 32'(tmo), 32'(t == resp_cyc && exp_to));
      if (t >= 1) begin
        chk("wbs_adr", s_adr, adr);
        chk("wbs_we", 32'(s_we), 32'(we));
        chk("wbs_sel", 32'(s_sel), 32'(sel));
        chk("wbs_dat", 32'(s_wdat), 32'(wdat));
      end
      if (t == resp_cyc && !exp_err) exp_dat = rdata;
      chk("wbm_dat", 32'(m_rdat), 32'(exp_dat));
    end
  endtask

  task automatic reset_mid_access();
    @(posedge clk); #1;
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b1; m_sel = 2'b11;
    m_adr = 32'h0000_0100; m_wdat = 16'hA5A5;
    s_ack = '0; s_err = '0;
    @(negedge clk);
    for (int unsigned t = 1; t <= 2; t++) begin
      @(posedge clk); #1;
      master_idle();
      @(negedge clk);
      chk("rst_pre_cyc", 32'(s_cyc), 32'd1);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("rst_cyc_drop", 32'(s_cyc), 32'd0);
    chk("rst_adr", s_adr, 32'd0);
    chk("rst_rdat", 32'(m_rdat), 32'd0);
    exp_dat = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
  endtask

  initial begin
    rst_n = 1'b0;
    master_idle();
    s_ack = '0; s_err = '0; s_rdat = '0;
    #1;
    chk("rst_cyc", 32'(s_cyc), 32'd0);
    chk("rst_ack", 32'(m_ack), 32'd0);
    chk("rst_err", 32'(m_err), 32'd0);
    chk("rst_tmo", 32'(tmo), 32'd0);
    chk("rst_wadr", s_adr, 32'd0);
    chk("rst_rdat0", 32'(m_rdat), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // read slave 2, ack in the 3rd strobe cycle with 0xBEEF
    run_txn(2'd2, 1'b0, 2'b11, 16'h0000, 32'h0002_0010, 16'hBEEF, 2, 0, 0, 0);
    // write slave 0, combinational ack
    run_txn(2'd0, 1'b1, 2'b10, 16'h1234, 32'h0000_0040, 16'h5555, 0, 0, 0, 0);
    // unmapped index 3
    run_txn(2'd3, 1'b0, 2'b11, 16'h0000, 32'h0003_0000, 16'h7777, 0, 0, 0, 0);
    // hung slave 1 -> timeout, then a normal access
    run_txn(2'd1, 1'b0, 2'b01, 16'h0000, 32'h0001_0008, 16'h1111, 100, 0, 0, 0);
    run_txn(2'd1, 1'b0, 2'b11, 16'h0000, 32'h0001_0004, 16'h2222, 1, 0, 0, 0);
    // ack+err together with spurious responses from the other slaves
    run_txn(2'd1, 1'b0, 2'b11, 16'h0000, 32'h0001_000C, 16'hDEAD, 1, 2, 1, 0);
    // response in the final permitted cycle beats the timeout
    run_txn(2'd0, 1'b0, 2'b11, 16'h0000, 32'h0000_0000, 16'hC0DE, TO - 1, 0, 0, 0);
    reset_mid_access();
    run_txn(2'd2, 1'b1, 2'b01, 16'h4321, 32'h0002_0020, 16'h0F0F, 0, 0, 0, 1);

    for (int i = 0; i < 60; i++) begin
      run_txn(2'($urandom), 1'($urandom), 2'($urandom), 16'($urandom), $urandom,
              16'($urandom), $urandom_range(0, TO + 2), $urandom_range(0, 2),
              1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
